// File: rtl/l1_dcache_req_arb.sv
// l1_dcache_req_arb: round-robin arbiter merging NUM_CH requester channels
// into one L1 D-cache request port, with response routing back by channel.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/ready/we        per-channel handshake and write enable
//   req_addr/wdata/tag        packed per-channel request fields
//   mem_req_*                 registered downstream request (one entry)
//   mem_rsp_valid/data/tag    downstream response, tag = {channel, req tag}
//   rsp_valid/data/tag        per-channel response valid, shared data/tag
//
// Optional feature: define L1DS_ARB_OUTSTANDING_LIMIT_EN to add a 4-bit
// outstanding-request counter per channel; a channel at MAX_OUTS is not granted.
module l1_dcache_req_arb #(
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int TAG_W    = 4,
    parameter int MAX_OUTS = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_CH-1:0]                           req_valid,
    output logic [NUM_CH-1:0]                           req_ready,
    input  logic [NUM_CH-1:0]                           req_we,
    input  logic [NUM_CH*ADDR_W-1:0]                    req_addr,
    input  logic [NUM_CH*DATA_W-1:0]                    req_wdata,
    input  logic [NUM_CH*TAG_W-1:0]                     req_tag,
    output logic                                        mem_req_valid,
    input  logic                                        mem_req_ready,
    output logic                                        mem_req_we,
    output logic [ADDR_W-1:0]                           mem_req_addr,
    output logic [DATA_W-1:0]                           mem_req_wdata,
    output logic [((NUM_CH > 2) ? $clog2(NUM_CH) : 1)+TAG_W-1:0] mem_req_tag,
    input  logic                                        mem_rsp_valid,
    input  logic [DATA_W-1:0]                           mem_rsp_data,
    input  logic [((NUM_CH > 2) ? $clog2(NUM_CH) : 1)+TAG_W-1:0] mem_rsp_tag,
    output logic [NUM_CH-1:0]                           rsp_valid,
    output logic [DATA_W-1:0]                           rsp_data,
    output logic [TAG_W-1:0]                            rsp_tag
);

    localparam int CH_W = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH);
    localparam int MT_W = CH_W + TAG_W;

    logic              r_full;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [MT_W-1:0]   r_tag;
    logic [CH_W-1:0]   r_last;
    logic [NUM_CH-1:0] r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic [TAG_W-1:0]  r_rsp_tag;

    logic [NUM_CH-1:0] w_elig;
    logic              w_free;
    logic              w_gnt_any;
    logic              w_take;
    logic [CH_W-1:0]   w_gnt_id;
    logic [NUM_CH-1:0] w_gnt;
    int                w_best;
    int                w_dist;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [TAG_W-1:0]  w_sel_tag;
    logic [CH_W-1:0]   w_rsp_ch;
    logic              w_rsp_ok;
    logic [NUM_CH-1:0] w_rsp_hit;

    // Entry can take a new request if empty or being drained this cycle.
    assign w_free = !r_full || mem_req_ready;

    // Pick the eligible channel with the smallest rotational distance
    // from the channel after the last grant.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_best    = NUM_CH;
        w_dist    = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_dist = (i + NUM_CH - 1 - int'(r_last)) % NUM_CH;
            if (w_elig[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_gnt_id  = CH_W'(i);
                w_gnt_any = 1'b1;
            end
        end
    end

    assign w_take    = w_gnt_any && w_free && !rst;
    assign w_gnt     = w_take ? (NUM_CH'(1) << w_gnt_id) : '0;
    assign req_ready = w_gnt;

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_tag   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt_id == CH_W'(i)) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                w_sel_tag   = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_tag   <= '0;
            r_last  <= CH_W'(NUM_CH - 1);
        end else if (w_take) begin
            r_full  <= 1'b1;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_tag   <= {w_gnt_id, w_sel_tag};
            r_last  <= w_gnt_id;
        end else if (mem_req_ready) begin
            r_full  <= 1'b0;
        end
    end

    assign mem_req_valid = r_full;
    assign mem_req_we    = r_we;
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;
    assign mem_req_tag   = r_tag;

    // Responses for nonexistent channels are dropped entirely.
    assign w_rsp_ch  = mem_rsp_tag[MT_W-1:TAG_W];
    assign w_rsp_ok  = mem_rsp_valid && (int'(w_rsp_ch) < NUM_CH);
    assign w_rsp_hit = w_rsp_ok ? (NUM_CH'(1) << w_rsp_ch) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_tag   <= '0;
        end else begin
            r_rsp_valid <= w_rsp_hit;
            if (w_rsp_ok) begin
                r_rsp_data <= mem_rsp_data;
                r_rsp_tag  <= mem_rsp_tag[TAG_W-1:0];
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_tag   = r_rsp_tag;

`ifdef L1DS_ARB_OUTSTANDING_LIMIT_EN
    logic [3:0] r_cnt [NUM_CH];

    // Grant and response together leave the count unchanged; responses
    // for requests issued before a reset saturate at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_gnt[i] && !w_rsp_hit[i])
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                else if (!w_gnt[i] && w_rsp_hit[i] && (r_cnt[i] != 4'd0))
                    r_cnt[i] <= r_cnt[i] - 4'd1;
            end
        end
    end

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_elig[i] = req_valid[i] && (r_cnt[i] != 4'(MAX_OUTS));
    end
`else
    assign w_elig = req_valid;
`endif

endmodule

// File: doc/l1_dcache_req_arb.md
L1_DCACHE_REQ_ARB -- requirements
Module: l1_dcache_req_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of requester channels (prefetch, gluon, vector); legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32: request address width.
REQ-003 SHALL have parameter DATA_W, default 64: write and response data width.
REQ-004 SHALL have parameter TAG_W, default 4: per-channel request tag width.
REQ-005 SHALL have parameter MAX_OUTS, default 4: per-channel outstanding-request limit; legal range 1..15.
REQ-006 SHALL have localparam CH_W = max(1, clog2(NUM_CH)).
REQ-007 Ports SHALL be exactly as follows; one clock, reset asynchronous and active-high:
  clk  in  1  clock, all state on rising edge
  rst  in  1  asynchronous active-high reset
  req_valid  in  NUM_CH  per-channel request valid
  req_ready  out  NUM_CH  per-channel request accepted
  req_we  in  NUM_CH  per-channel write enable
  req_addr  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
  req_wdata  in  NUM_CH*DATA_W  packed write data
  req_tag  in  NUM_CH*TAG_W  packed requester tags
  mem_req_valid  out  1  downstream request valid
  mem_req_ready  in  1  downstream accepts request
  mem_req_we / mem_req_addr / mem_req_wdata  out  1/ADDR_W/DATA_W  granted request fields
  mem_req_tag  out  CH_W+TAG_W  {channel id, requester tag}
  mem_rsp_valid  in  1  downstream response valid (no backpressure)
  mem_rsp_data  in  DATA_W  response data
  mem_rsp_tag  in  CH_W+TAG_W  echoed mem_req_tag
  rsp_valid  out  NUM_CH  per-channel response valid
  rsp_data  out  DATA_W  response data, shared by all channels
  rsp_tag  out  TAG_W  requester tag of returned response

Function
REQ-008 SHALL hold a one-entry output register for mem_req_*; entry is free when empty, or when full and mem_req_ready=1 in the same cycle.
REQ-009 SHALL grant at most one channel per cycle, only when the output entry is free; req_ready[i]=1 only for the granted channel, and only when req_valid[i]=1 and channel i is eligible.
REQ-010 SHALL arbitrate round-robin: search starts at the channel after the last granted one, wrapping from NUM_CH-1 to 0; pointer updates only on a grant; after reset search starts at channel 0.
REQ-011 Latency: request granted in cycle N SHALL appear on mem_req_* with mem_req_valid=1 in cycle N+1; mem_req_* SHALL hold stable while mem_req_valid=1 and mem_req_ready=0.
REQ-012 Full output entry with mem_req_ready=1 and a new grant in the same cycle SHALL load the new request without a bubble.
REQ-013 Response routing: mem_rsp_valid in cycle N SHALL assert rsp_valid[ch] in cycle N+1 only, with ch = mem_rsp_tag[CH_W+TAG_W-1:TAG_W], rsp_tag = low TAG_W bits, rsp_data = mem_rsp_data registered.
REQ-014 A response whose channel id is >= NUM_CH SHALL be dropped, with no rsp_valid bit set and no counter change.
REQ-015 rsp_data and rsp_tag SHALL hold their last value when rsp_valid is all zero.

Reset
REQ-016 While rst=1: req_ready=0, mem_req_valid=0, rsp_valid=0, mem_req_addr/wdata/tag/we=0, rsp_data=0, rsp_tag=0, round-robin pointer at last=NUM_CH-1 so channel 0 is searched first, all outstanding counters 0.
REQ-017 Reset asserted mid-transaction SHALL discard the held request and all outstanding counts immediately; responses arriving after release for pre-reset requests SHALL still be routed per REQ-013, with counters saturating at 0.

Configuration
REQ-018 Macro L1DS_ARB_OUTSTANDING_LIMIT_EN compiled in: per-channel 4-bit counter, incremented on grant and decremented on routed response, unchanged when both happen in the same cycle; a channel whose count equals MAX_OUTS is ineligible for grant.
REQ-019 Without L1DS_ARB_OUTSTANDING_LIMIT_EN: no counters exist and every valid channel is always eligible.

Verification
REQ-020 All three channels valid continuously, mem_req_ready=1 -> grants in order 0,1,2,0,1,2; one mem_req per cycle from cycle 1.
REQ-021 Channel 1 write, addr 0x1000, tag 0x5; mem_req_ready low for 3 cycles -> mem_req_addr=0x1000, mem_req_tag={2'd1,4'h5} stable 3 cycles; req_ready=0 for all channels until accepted.
REQ-022 mem_rsp_valid with tag {2'd2,4'hA}, data 0xDEAD -> next cycle rsp_valid=3'b100, rsp_tag=0xA, rsp_data=0xDEAD; mem_rsp_tag {2'd3,x} -> no rsp_valid.
REQ-023 LIMIT_EN, MAX_OUTS=4, channel 0 always valid, no responses -> exactly 4 grants to ch0; one response to ch0 -> exactly one more grant.
REQ-024 rst pulsed while mem_req_valid=1 -> mem_req_valid=0 in the same cycle; first grant after release goes to channel 0.
